// File: rtl/text_overlay_pkg.sv
// Shared constants for the text overlay engine.
// Holds the character-buffer entry layout {blink, color[2:0], char[6:0]},
// the blank character, the background colour and the character cell geometry.
package text_overlay_pkg;

   localparam int ENTRY_W   = 11;
   localparam int CHAR_W    = 7;
   localparam int CHAR_LSB  = 0;
   localparam int COLOR_W   = 3;
   localparam int COLOR_LSB = 7;
   localparam int BLINK_BIT = 10;

   localparam logic [CHAR_W-1:0]  BLANK_CHAR = 7'h00;
   localparam logic [COLOR_W-1:0] BG_RGB     = 3'b111;
   localparam logic [ENTRY_W-1:0] BLANK_ENTRY = {1'b0, 3'b000, BLANK_CHAR};

   // Font is 8x16, drawn 2x scaled into 16x32 screen-pixel cells.
   localparam int FONT_W = 8;
   localparam int FONT_H = 16;
   localparam int CELL_W = 16;
   localparam int CELL_H = 32;

   function automatic logic [CHAR_W-1:0] entry_char(input logic [ENTRY_W-1:0] e);
      return e[CHAR_LSB +: CHAR_W];
   endfunction

   function automatic logic [COLOR_W-1:0] entry_color(input logic [ENTRY_W-1:0] e);
      return e[COLOR_LSB +: COLOR_W];
   endfunction

   function automatic logic entry_blink(input logic [ENTRY_W-1:0] e);
      return e[BLINK_BIT];
   endfunction

endpackage

// File: rtl/text_overlay_engine_font_rom.sv
// font_rom: synchronous 128-glyph x 16-row font, 8 pixels per row, MSB is the
// leftmost pixel. Glyph 0 is blank; 'A' and 'H' carry their usual shapes, the
// remaining codes hold a fixed filler pattern.
// Ports: clk - clock; addr - {char[6:0], glyph_row[3:0]}; data - row bits (1 clk later).
module font_rom (
   input  logic        clk,
   input  logic [10:0] addr,
   output logic [7:0]  data
);

   function automatic logic [7:0] glyph(input logic [6:0] ch, input logic [3:0] row);
      logic [7:0] g;
      g = 8'h00;
      case (ch)
         7'h00: g = 8'h00;
         7'h41: begin
            case (row)
               4'd2:    g = 8'h10;
               4'd3:    g = 8'h38;
               4'd4:    g = 8'h6C;
               4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: g = 8'hC6;
               4'd7:    g = 8'hFE;
               default: g = 8'h00;
            endcase
         end
         7'h48: begin
            case (row)
               4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: g = 8'hC6;
               4'd6:    g = 8'hFE;
               default: g = 8'h00;
            endcase
         end
         default: g = (({1'b0, ch} * 8'd29) + ({4'd0, row} * 8'd53)) ^ 8'h5A;
      endcase
      return g;
   endfunction

   always_ff @(posedge clk) begin
      data <= glyph(addr[10:4], addr[3:0]);
   end

endmodule

// File: rtl/text_overlay_engine.sv
// text_overlay_engine: character-cell text overlay for a VGA pixel stream.
// A NUM_ROWS x ROW_CHARS buffer of {blink, color, char} entries is rendered
// with a 2x-scaled 8x16 font. Output latency from pix_x/pix_y is 2 clocks:
// edge 1 registers the cell fields and the font ROM row together, edge 2
// registers the final pixel.
// Ports:
//   clk, reset             - clock, async active-high reset
//   pix_x, pix_y           - current pixel coordinate
//   frame_tick             - one pulse per frame, drives the blink timer
//   wr_en/wr_row/wr_col/wr_data - buffer write port
//   cursor_en/cursor_row/cursor_col - inverted-video cursor cell
//   text_on                - one-hot logical row under the pixel (0 outside text)
//   text_rgb               - pixel colour
module text_overlay_engine
   import text_overlay_pkg::*;
#(
   parameter int NUM_ROWS     = 9,
   parameter int ROW_CHARS    = 16,
   parameter int ROW_BASE     = 1,
   parameter int BLINK_FRAMES = 30,
   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
   localparam int COL_W   = (ROW_CHARS > 1) ? $clog2(ROW_CHARS) : 1,
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [9:0]          pix_x,
   input  logic [9:0]          pix_y,
   input  logic                frame_tick,
   input  logic                wr_en,
   input  logic [ROW_W-1:0]    wr_row,
   input  logic [COL_W-1:0]    wr_col,
   input  logic [ENTRY_W-1:0]  wr_data,
   input  logic                cursor_en,
   input  logic [ROW_W-1:0]    cursor_row,
   input  logic [COL_W-1:0]    cursor_col,
   output logic [NUM_ROWS-1:0] text_on,
   output logic [2:0]          text_rgb
);

   logic [ENTRY_W-1:0] char_mem [NUM_ROWS][ROW_CHARS];

   logic               wr_ok;
   logic [4:0]         trow;
   logic [5:0]         col;
   logic               in_area;
   logic [ROW_W-1:0]   trow_idx;
   logic [COL_W-1:0]   col_idx;
   logic [ENTRY_W-1:0] rd_entry;
   logic               cursor_hit;
   logic [10:0]        font_addr;
   logic [7:0]         font_word;

   logic               s1_valid;
   logic               s1_in_area;
   logic [ROW_W-1:0]   s1_row;
   logic [2:0]         s1_bit;
   logic [COLOR_W-1:0] s1_color;
   logic               s1_blink;
   logic               s1_cursor;

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   logic               fg;
   logic [NUM_ROWS-1:0] nxt_on;
   logic [2:0]          nxt_rgb;

   // Pixel bit 0 is below the 2x scaling resolution.
   logic unused_pix;
   assign unused_pix = pix_x[0] ^ pix_y[0];

   // ---------------- character buffer ----------------
   assign wr_ok = (32'(wr_row) < NUM_ROWS) && (32'(wr_col) < ROW_CHARS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < ROW_CHARS; c++) begin
               char_mem[r][c] <= BLANK_ENTRY;
            end
         end
      end else if (wr_en && wr_ok) begin
         char_mem[wr_row][wr_col] <= wr_data;
      end
   end

   // ---------------- stage 0: cell lookup ----------------
   // Rows above ROW_BASE underflow to a large trow and fall out of the area.
   assign trow     = pix_y[9:5] - 5'(ROW_BASE);
   assign col      = pix_x[9:4];
   assign in_area  = (32'(trow) < NUM_ROWS) && (32'(col) < ROW_CHARS);
   assign trow_idx = trow[ROW_W-1:0];
   assign col_idx  = col[COL_W-1:0];
   assign rd_entry = in_area ? char_mem[trow_idx][col_idx] : BLANK_ENTRY;
   assign cursor_hit = cursor_en && (trow_idx == cursor_row) && (col_idx == cursor_col);
   assign font_addr  = {entry_char(rd_entry), pix_y[4:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_in_area <= 1'b0;
         s1_row     <= '0;
         s1_bit     <= '0;
         s1_color   <= '0;
         s1_blink   <= 1'b0;
         s1_cursor  <= 1'b0;
      end else begin
         s1_valid   <= 1'b1;
         s1_in_area <= in_area;
         s1_row     <= trow_idx;
         s1_bit     <= pix_x[3:1];
         s1_color   <= entry_color(rd_entry);
         s1_blink   <= entry_blink(rd_entry);
         s1_cursor  <= cursor_hit;
      end
   end

   // ---------------- stage 1: font ROM ----------------
   // The ROM address comes straight from stage 0, so the glyph row lands on
   // the same edge as the registered cell fields.
   font_rom u_font_rom (
      .clk  (clk),
      .addr (font_addr),
      .data (font_word)
   );

   // ---------------- blink timer ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // ---------------- stage 2: pixel colour ----------------
   always_comb begin
      nxt_on  = '0;
      nxt_rgb = BG_RGB;
      fg      = font_word[~s1_bit] && !(s1_blink && blink_phase);
      if (s1_valid && s1_in_area) begin
         nxt_on = NUM_ROWS'(1) << s1_row;
         if (s1_cursor) begin
            nxt_rgb = fg ? BG_RGB : s1_color;
         end else begin
            nxt_rgb = fg ? s1_color : BG_RGB;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         text_on  <= '0;
         text_rgb <= BG_RGB;
      end else begin
         text_on  <= nxt_on;
         text_rgb <= nxt_rgb;
      end
   end

endmodule

// File: tb/tb_text_overlay_engine.sv
// Self-checking bench for text_overlay_engine: directed scenarios plus a
// randomized mix of writes, scans, frame ticks and cursor moves, all compared
// against a pixel-level model of the text screen.
module tb_text_overlay_engine;

   localparam int NR = 9;
   localparam int RC = 16;
   localparam int RB = 1;
   localparam int BF = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pix_x = '0;
   logic [9:0]  pix_y = '0;
   logic        frame_tick = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_row = '0;
   logic [3:0]  wr_col = '0;
   logic [10:0] wr_data = '0;
   logic        cursor_en = 1'b0;
   logic [3:0]  cursor_row = '0;
   logic [3:0]  cursor_col = '0;
   logic [NR-1:0] text_on;
   logic [2:0]  text_rgb;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   int model_mem [NR][RC];
   int model_cnt   = 0;
   int model_phase = 0;

   text_overlay_engine #(
      .NUM_ROWS(NR), .ROW_CHARS(RC), .ROW_BASE(RB), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
      .frame_tick(frame_tick), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .cursor_en(cursor_en), .cursor_row(cursor_row),
      .cursor_col(cursor_col), .text_on(text_on), .text_rgb(text_rgb)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic int font_row(input int ch, input int row);
      if (ch == 0) return 0;
      if (ch == 'h48) begin
         if (row == 6) return 'hFE;
         if (row >= 2 && row <= 11) return 'hC6;
         return 0;
      end
      if (ch == 'h41) begin
         case (row)
            2: return 'h10;
            3: return 'h38;
            4: return 'h6C;
            7: return 'hFE;
            default: return (row >= 5 && row <= 11) ? 'hC6 : 0;
         endcase
      end
      return ((ch * 29 + row * 53) % 256) ^ 'h5A;
   endfunction

   task automatic model_pix(input int px, input int py, output int on, output int rgb);
      int trow, col, e, ch, color, blink, bit_v, fg, cur;
      trow = py / 32 - RB;
      col  = px / 16;
      on = 0;
      rgb = 7;
      if (trow >= 0 && trow < NR && col < RC) begin
         e     = model_mem[trow][col];
         ch    = e % 128;
         color = (e / 128) % 8;
         blink = (e / 1024) % 2;
         bit_v = (font_row(ch, (py % 32) / 2) >> (7 - (px % 16) / 2)) & 1;
         fg    = (bit_v == 1 && !(blink == 1 && model_phase == 1)) ? 1 : 0;
         cur   = (cursor_en && trow == int'(cursor_row) && col == int'(cursor_col)) ? 1 : 0;
         if (cur == 1) rgb = (fg == 1) ? 7 : color;
         else          rgb = (fg == 1) ? color : 7;
         on = 1 << trow;
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < RC; c++)
            model_mem[r][c] = 0;
      model_cnt = 0;
      model_phase = 0;
   endtask

   // ---------------- stimulus helpers (all entered at posedge+1) ----------------
   task automatic do_write(input int row, input int col, input int data);
      wr_en = 1'b1;
      wr_row = 4'(row);
      wr_col = 4'(col);
      wr_data = 11'(data);
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (row < NR && col < RC) model_mem[row][col] = data;
   endtask

   task automatic do_tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(posedge clk); #1;
         frame_tick = 1'b0;
         if (model_cnt == BF - 1) begin
            model_cnt = 0;
            model_phase = 1 - model_phase;
         end else begin
            model_cnt++;
         end
      end
   endtask

   task automatic scan(input int px, input int py, input string tag);
      int eon, ergb;
      pix_x = 10'(px);
      pix_y = 10'(py);
      @(posedge clk);
      @(posedge clk); #1;
      model_pix(px, py, eon, ergb);
      check_val({tag, "_on"}, 32'(text_on), eon);
      check_val({tag, "_rgb"}, 32'(text_rgb), ergb);
   endtask

   initial begin
      int eon, ergb, op;
      model_clear();
      #12;
      // Reset state
      check_val("rst_on", 32'(text_on), 0);
      check_val("rst_rgb", 32'(text_rgb), 7);
      @(posedge clk); #1;
      reset = 1'b0;

      // 'H' in row 0 col 2, colour 001: whole cell
      do_write(0, 2, {1'b0, 3'b001, 7'h48});
      for (int y = 32; y < 64; y++)
         for (int x = 32; x < 48; x++)
            scan(x, y, "h_cell");

      // Same-cycle write and display: old value first, new the cycle after
      pix_x = 10'd36; pix_y = 10'd44;   // 'H' glyph row 6, column 2: foreground
      wr_en = 1'b1; wr_row = 4'd0; wr_col = 4'd2; wr_data = {1'b0, 3'b100, 7'h48};
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk); #1;
      check_val("wr_same_old", 32'(text_rgb), 1);
      model_mem[0][2] = {1'b0, 3'b100, 7'h48};
      @(posedge clk); #1;
      check_val("wr_same_new", 32'(text_rgb), 4);

      // Blink: row 1 col 0 'A' colour 010, glyph pixel on row 7 of the font
      do_write(1, 0, {1'b1, 3'b010, 7'h41});
      scan(2, 78, "blink_ph0");
      do_tick(29);
      scan(2, 78, "blink_29");
      do_tick(1);
      scan(2, 78, "blink_ph1");
      scan(20, 78, "blink_ph1_bg");
      do_tick(30);
      scan(2, 78, "blink_back");

      // Cursor at row 3 col 5 on 'A' colour 000
      do_write(3, 5, {1'b0, 3'b000, 7'h41});
      do_write(3, 4, {1'b0, 3'b011, 7'h41});
      cursor_en = 1'b1; cursor_row = 4'd3; cursor_col = 4'd5;
      for (int y = 128; y < 160; y += 3)
         for (int x = 80; x < 96; x += 2)
            scan(x, y, "cursor");
      scan(70, 142, "cursor_nbr");
      cursor_en = 1'b0;

      // Out-of-range row write is dropped
      scan(130, 280, "oor_before");
      do_write(NR, 8, {1'b0, 3'b101, 7'h48});
      do_write(15, 0, {1'b0, 3'b101, 7'h48});
      scan(130, 280, "oor_after");
      scan(2, 290, "oor_row8");

      // Outside the text area
      scan(0, 0, "above");
      scan(300, 40, "col18");
      scan(100, 479, "below");

      // Randomized mix
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 9);
         if (op <= 2) begin
            do_write($urandom_range(0, 10), $urandom_range(0, 15),
                     ($urandom_range(0, 1) * 1024) + ($urandom_range(0, 7) * 128) +
                     (($urandom_range(0, 2) == 0) ? 'h48 : $urandom_range(0, 127)));
         end else if (op <= 7) begin
            scan($urandom_range(0, 299), $urandom_range(0, 359), "rand");
         end else if (op == 8) begin
            do_tick($urandom_range(1, 20));
         end else begin
            cursor_en  = 1'($urandom_range(0, 1));
            cursor_row = 4'($urandom_range(0, 8));
            cursor_col = 4'($urandom_range(0, 15));
         end
      end
      cursor_en = 1'b0;

      // Reset after filling: immediate background, buffer blank on release
      do_write(2, 1, {1'b0, 3'b001, 7'h48});
      scan(20, 108, "pre_rst");
      reset = 1'b1;
      #1;
      check_val("rst_async_on", 32'(text_on), 0);
      check_val("rst_async_rgb", 32'(text_rgb), 7);
      wr_en = 1'b1; wr_row = 4'd2; wr_col = 4'd1; wr_data = {1'b0, 3'b010, 7'h48};
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk); #1;
      check_val("rst_hold_rgb", 32'(text_rgb), 7);
      model_clear();
      reset = 1'b0;
      @(posedge clk); #1;
      check_val("rst_lat1_on", 32'(text_on), 0);
      check_val("rst_lat1_rgb", 32'(text_rgb), 7);
      @(posedge clk); #1;
      model_pix(20, 108, eon, ergb);
      check_val("rst_lat2_on", 32'(text_on), eon);
      check_val("rst_lat2_rgb", 32'(text_rgb), ergb);
      scan(20, 108, "post_rst");
      scan(36, 44, "post_rst_h");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/text_overlay_engine.md
TEXT_OVERLAY_ENGINE -- requirements
Module: text_overlay_engine

Interface
REQ-001 Parameter NUM_ROWS, default 9: number of logical text rows held in the character buffer.
REQ-002 Parameter ROW_CHARS, default 16: characters per row; each character cell is 16x32 screen pixels (font 8x16 scaled 2x).
REQ-003 Parameter ROW_BASE, default 1: screen text row (pix_y[9:5]) where logical row 0 is displayed.
REQ-004 Parameter BLINK_FRAMES, default 30: frame_tick pulses per blink phase toggle.
REQ-005 clk  in  1  system clock; the block uses one clock; all state is clocked on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pix_x, pix_y  in  10 each  current pixel coordinates from the VGA sync generator.
REQ-008 frame_tick  in  1  one-cycle pulse once per frame.
REQ-009 wr_en  in  1  character buffer write strobe.
REQ-010 wr_row  in  $clog2(NUM_ROWS)  row to write; wr_col  in  $clog2(ROW_CHARS)  column to write.
REQ-011 wr_data  in  11  {blink, color[2:0], char[6:0]}.
REQ-012 cursor_en  in  1; cursor_row, cursor_col  in  widths as wr_row/wr_col  inverted-video cursor cell.
REQ-013 text_on  out  NUM_ROWS  one-hot flag of the logical row under the pixel, 0 outside the text area.
REQ-014 text_rgb  out  3  pixel colour.

Function
REQ-015 Buffer holds NUM_ROWS*ROW_CHARS 11-bit entries; a write with wr_en=1 SHALL update the entry at the next rising edge.
REQ-016 Writes with wr_row>=NUM_ROWS or wr_col>=ROW_CHARS SHALL be ignored with no side effect.
REQ-017 Pipeline stage 0 SHALL compute trow=pix_y[9:5]-ROW_BASE, col=pix_x[9:4], in_area=(trow<NUM_ROWS)&&(col<ROW_CHARS), read the buffer entry combinationally, and register {char, pix_y[4:1], pix_x[3:1], attributes, in_area, cursor hit}.
REQ-018 Stage 1 SHALL be the synchronous font ROM read at address {char, row}, with the stage-0 fields delayed alongside.
REQ-019 Stage 2 SHALL register text_on and text_rgb; total latency from pix_x/pix_y to outputs is exactly 2 clocks.
REQ-020 font_bit = font_word[~bit_addr]; pixel is foreground when font_bit=1 and not (blink=1 and blink_phase=1).
REQ-021 In area, non-cursor: foreground -> color, background -> 3'b111.
REQ-022 Cursor cell (cursor_en=1, row/col match): foreground -> 3'b111, background -> color; blink suppression still applies to the glyph.
REQ-023 Outside area: text_on=0, text_rgb=3'b111.
REQ-024 Blink counter counts frame_tick pulses 0..BLINK_FRAMES-1; on the pulse at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-025 Write and display of the same entry in the same cycle: display uses the old value; new value visible from the next cycle.
REQ-026 ROW_BASE+NUM_ROWS beyond 15 rows: rows off-screen never displayed; no wrap of trow (subtraction underflow yields in_area=0).

Reset
REQ-027 On reset assertion, immediately: all buffer entries = 11'h000, blink counter=0, blink_phase=0, pipeline valid flags=0, text_on=0, text_rgb=3'b111.
REQ-028 Reset mid-frame: outputs show background from assertion until 2 clocks after deassertion; writes during reset are discarded.

Structure
REQ-029 Package text_overlay_pkg SHALL hold attribute field positions/widths, BLANK_CHAR=7'h00, BG_RGB=3'b111, cell size constants.
REQ-030 The existing font_rom SHALL be instantiated as the single sub-module (clk, addr[10:0], data[7:0]); no other sub-modules.

Verification
REQ-031 Write row0 col2 = {0,3'b001,7'h48}; scan pixel (32..47, 32..63) -> after 2 clocks text_on=9'b1, 'H' glyph pixels 3'b001, others 3'b111.
REQ-032 Write blink=1 entry; issue 30 frame_ticks -> glyph hidden (all 3'b111) during phase 1, visible after 30 more.
REQ-033 cursor_en=1 at row 3 col 5 holding 'A' colour 3'b000 -> glyph pixels 3'b111, background 3'b000 in that cell only.
REQ-034 Write wr_row=NUM_ROWS -> buffer unchanged, display identical before/after.
REQ-035 pix_y=0 (above ROW_BASE) and pix_x=300 (col 18) -> text_on=0, text_rgb=3'b111.
REQ-036 Assert reset after filling buffer -> outputs 3'b111 immediately, buffer reads blank after release.
